// File: rtl/msx_bus_trace_capture.sv
`default_nettype none
// ============================================================================
// Module   : msx_bus_trace_capture
// Purpose  : On-chip trace buffer for MSX bus / demux signals. Run-time
//            trigger units (masked compare, level or edge), AND/OR combine,
//            pre/post-trigger split, circular capture and register readout.
// Revision : 1.0 - initial release
// ============================================================================
module msx_bus_trace_capture #(
    parameter int DATA_W     = 50,
    parameter int DEPTH_LOG2 = 10,
    parameter int NUM_TRIG   = 4
) (
    input  logic                         clk_108m,
    input  logic                         reset,
    input  logic                         sample_en,
    input  logic [DATA_W-1:0]            data_i,
    input  logic                         arm,
    input  logic                         abort,
    input  logic                         force_trig,
    input  logic [NUM_TRIG-1:0]          trig_en,
    input  logic [NUM_TRIG-1:0]          trig_edge,
    input  logic                         trig_and,
    input  logic [NUM_TRIG*DATA_W-1:0]   trig_value,
    input  logic [NUM_TRIG*DATA_W-1:0]   trig_mask,
    input  logic [DEPTH_LOG2-1:0]        post_count,
    output logic                         busy,
    output logic                         triggered,
    output logic                         done,
    output logic [DEPTH_LOG2:0]          sample_count,
    output logic [DEPTH_LOG2-1:0]        trig_offset,
    input  logic [DEPTH_LOG2-1:0]        rd_addr,
    output logic [DATA_W-1:0]            rd_data
);

    localparam int                  c_DEPTH = 2**DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_FULL  = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_POST = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [DATA_W-1:0]       r_mem [c_DEPTH];
    logic [DATA_W-1:0]       r_rd_data;
    logic [DEPTH_LOG2-1:0]   r_wr_ptr;
    logic [DEPTH_LOG2:0]     r_count;
    logic [DEPTH_LOG2-1:0]   r_trig_ptr;
    logic [DEPTH_LOG2-1:0]   r_post_rem;
    logic [NUM_TRIG-1:0]     r_prev_match;
    logic                    r_force_pend;
    logic                    r_triggered;

    logic [NUM_TRIG-1:0]     w_match;
    logic [NUM_TRIG-1:0]     w_hit;
    logic                    w_hit_or;
    logic                    w_hit_and;
    logic                    w_comb_hit;
    logic                    w_capturing;
    logic                    w_accept;
    logic                    w_arm_go;
    logic                    w_fire;
    logic [DEPTH_LOG2-1:0]   w_start_ptr;
    logic [DEPTH_LOG2-1:0]   w_rd_phys;

    // Per-unit masked compare; edge mode needs a non-match on the previous
    // accepted sample, so an all-ones prev_match suppresses the first sample.
    for (genvar k = 0; k < NUM_TRIG; k++) begin : g_trig
        assign w_match[k] = ((data_i ^ trig_value[k*DATA_W +: DATA_W])
                             & trig_mask[k*DATA_W +: DATA_W]) == '0;
        assign w_hit[k]   = w_match[k] & (~trig_edge[k] | ~r_prev_match[k]);
    end

    // Disabled units are neutral in both combine modes; with no unit enabled
    // the AND form must not hit, hence the explicit non-empty test.
    assign w_hit_or   = |(w_hit & trig_en);
    assign w_hit_and  = (trig_en != '0) && ((w_hit | ~trig_en) == '1);
    assign w_comb_hit = trig_and ? w_hit_and : w_hit_or;

    // Abort wins over everything, including the sample offered that cycle.
    assign w_capturing = (r_state == S_WAIT) || (r_state == S_POST);
    assign w_accept    = w_capturing & sample_en & ~abort;
    assign w_arm_go    = arm & ~abort & ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_fire      = w_accept & (r_state == S_WAIT)
                         & (w_comb_hit | r_force_pend | force_trig);

    // Oldest sample sits at 0 until the buffer first wraps, then at wr_ptr.
    assign w_start_ptr = r_count[DEPTH_LOG2] ? r_wr_ptr : '0;
    assign w_rd_phys   = w_start_ptr + rd_addr;

    assign busy         = w_capturing;
    assign done         = (r_state == S_DONE);
    assign triggered    = r_triggered;
    assign sample_count = r_count;
    assign trig_offset  = r_trig_ptr - w_start_ptr;
    assign rd_data      = r_rd_data;

    // State register.
    always_ff @(posedge clk_108m) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: arm only from IDLE/DONE, post phase skipped for a
    // zero post count, POST ends on the sample that exhausts the remainder.
    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (arm) w_state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    if (w_fire) w_state_nxt = (post_count == '0) ? S_DONE : S_POST;
                end
                S_POST: begin
                    if (w_accept && (r_post_rem == DEPTH_LOG2'(1))) w_state_nxt = S_DONE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Capture bookkeeping: write pointer, saturating count, trigger position,
    // post-trigger remainder and edge-detect history.
    always_ff @(posedge clk_108m) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_trig_ptr   <= '0;
            r_post_rem   <= '0;
            r_prev_match <= '1;
            r_triggered  <= 1'b0;
        end else if (w_arm_go) begin
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_trig_ptr   <= '0;
            r_prev_match <= '1;
            r_triggered  <= 1'b0;
        end else if (w_accept) begin
            r_wr_ptr     <= r_wr_ptr + DEPTH_LOG2'(1);
            r_prev_match <= w_match;
            if (r_count != c_FULL) begin
                r_count <= r_count + (DEPTH_LOG2+1)'(1);
            end
            if (w_fire) begin
                r_triggered <= 1'b1;
                r_trig_ptr  <= r_wr_ptr;
                r_post_rem  <= post_count;
            end else if (r_state == S_POST) begin
                r_post_rem  <= r_post_rem - DEPTH_LOG2'(1);
            end
        end
    end

    // Forced trigger is remembered until consumed by a WAIT_TRIG sample.
    always_ff @(posedge clk_108m) begin
        if (reset) begin
            r_force_pend <= 1'b0;
        end else if (abort || w_arm_go) begin
            r_force_pend <= 1'b0;
        end else if (w_accept && (r_state == S_WAIT)) begin
            r_force_pend <= 1'b0;
        end else if (force_trig) begin
            r_force_pend <= 1'b1;
        end
    end

    // Sample storage; kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk_108m) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    // Registered readout, relative to the oldest stored sample.
    always_ff @(posedge clk_108m) begin
        if (reset) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[w_rd_phys];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_msx_bus_trace_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_msx_bus_trace_capture
// Purpose  : Self-checking bench: directed and random captures against a
//            sample-list reference model; scoreboard queue + monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_msx_bus_trace_capture;

    localparam int DW = 50;
    localparam int DL = 4;
    localparam int NT = 4;
    localparam int DEPTH = 16;

    logic              clk = 1'b0;
    logic              reset, sample_en, arm, abort, force_trig, trig_and;
    logic [DW-1:0]     data_i;
    logic [NT-1:0]     trig_en, trig_edge;
    logic [NT*DW-1:0]  trig_value, trig_mask;
    logic [DL-1:0]     post_count, rd_addr;
    logic              busy, triggered, done;
    logic [DL:0]       sample_count;
    logic [DL-1:0]     trig_offset;
    logic [DW-1:0]     rd_data;

    always #5 clk = ~clk;

    msx_bus_trace_capture #(.DATA_W(DW), .DEPTH_LOG2(DL), .NUM_TRIG(NT)) dut (
        .clk_108m(clk), .reset(reset), .sample_en(sample_en), .data_i(data_i),
        .arm(arm), .abort(abort), .force_trig(force_trig),
        .trig_en(trig_en), .trig_edge(trig_edge), .trig_and(trig_and),
        .trig_value(trig_value), .trig_mask(trig_mask), .post_count(post_count),
        .busy(busy), .triggered(triggered), .done(done),
        .sample_count(sample_count), .trig_offset(trig_offset),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        string       name;
        int          sel;
        logic [63:0] exp;
        logic [63:0] msk;
    } chk_t;

    chk_t q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void push(input string n, input int s, input logic [63:0] e,
                                 input logic [63:0] m);
        chk_t c;
        c.name = n; c.sel = s; c.exp = e; c.msk = m;
        q.push_back(c);
    endfunction

    task automatic check_now(input string n, input logic [63:0] act,
                             input logic [63:0] e);
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", n, act, e, $time);
        end
    endtask

    // Monitor: compares every pending expectation against the stable outputs.
    always @(negedge clk) begin : mon
        chk_t        c;
        logic [63:0] act;
        while (q.size() > 0) begin
            c = q.pop_front();
            case (c.sel)
                0:       act = 64'(busy);
                1:       act = 64'(triggered);
                2:       act = 64'(done);
                3:       act = 64'(sample_count);
                4:       act = 64'(trig_offset);
                default: act = 64'(rd_data);
            endcase
            checks++;
            if ((act & c.msk) !== (c.exp & c.msk)) begin
                errors++;
                $display("FAIL %s: actual=%h required=%h (t=%0t)",
                         c.name, act & c.msk, c.exp & c.msk, $time);
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation did not finish in time (t=%0t)", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ---------------- reference model ----------------
    // Phases: 0 idle, 1 waiting for trigger, 2 post-trigger, 3 done.
    int            m_ph;
    logic [DW-1:0] m_samp[$];   // every accepted sample since arm
    int            m_trig_idx;
    bit            m_trig;
    bit            m_tvalid;    // triggered/offset not defined after abort
    bit            m_pend;
    int            m_rem;
    bit            m_prev[NT];

    function automatic void model_reset();
        m_ph = 0; m_samp.delete(); m_trig_idx = 0; m_trig = 0; m_tvalid = 1;
        m_pend = 0; m_rem = 0;
        for (int k = 0; k < NT; k++) m_prev[k] = 1;
    endfunction

    function automatic void model_step(input logic [DW-1:0] d, input bit sen,
                                       input bit a, input bit ab, input bit f);
        bit any_en, all_hit, any_hit, h, hit;
        bit mt[NT];
        logic [DW-1:0] v, m;
        if (ab) begin
            m_ph = 0; m_pend = 0; m_tvalid = 0;
        end else if (a && (m_ph == 0 || m_ph == 3)) begin
            m_ph = 1; m_samp.delete(); m_trig = 0; m_tvalid = 1; m_pend = 0;
            for (int k = 0; k < NT; k++) m_prev[k] = 1;
        end else begin
            if (f) m_pend = 1;
            if ((m_ph == 1 || m_ph == 2) && sen) begin
                m_samp.push_back(d);
                any_en = 0; all_hit = 1; any_hit = 0;
                for (int k = 0; k < NT; k++) begin
                    v = trig_value[k*DW +: DW];
                    m = trig_mask[k*DW +: DW];
                    mt[k] = (((d ^ v) & m) == '0);
                    h = trig_edge[k] ? (mt[k] && !m_prev[k]) : mt[k];
                    if (trig_en[k]) begin
                        any_en = 1;
                        if (h) any_hit = 1; else all_hit = 0;
                    end
                end
                for (int k = 0; k < NT; k++) m_prev[k] = mt[k];
                hit = trig_and ? (any_en && all_hit) : any_hit;
                if (m_ph == 1) begin
                    if (hit || m_pend) begin
                        m_trig = 1;
                        m_trig_idx = m_samp.size() - 1;
                        m_rem = int'(post_count);
                        m_ph = (m_rem == 0) ? 3 : 2;
                    end
                    m_pend = 0;
                end else begin
                    m_rem--;
                    if (m_rem == 0) m_ph = 3;
                end
            end
        end
    endfunction

    function automatic int m_count();
        return (m_samp.size() > DEPTH) ? DEPTH : m_samp.size();
    endfunction

    function automatic void push_status();
        int n, cnt, base;
        n = m_samp.size(); cnt = m_count(); base = n - cnt;
        push("busy", 0, 64'(m_ph == 1 || m_ph == 2), 64'h1);
        push("done", 2, 64'(m_ph == 3), 64'h1);
        push("sample_count", 3, 64'(cnt), '1);
        if (m_tvalid) push("triggered", 1, 64'(m_trig), 64'h1);
        if (m_tvalid && m_trig)
            push("trig_offset", 4, 64'(((m_trig_idx - base) % DEPTH + DEPTH) % DEPTH), '1);
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic logic [DW-1:0] mk(input logic [15:0] a, input bit iorq, input bit rdn);
        logic [DW-1:0] r;
        r[31:0]    = $urandom;
        r[DW-1:32] = (DW-32)'($urandom);
        r[15:0] = a; r[16] = iorq; r[17] = rdn;
        return r;
    endfunction

    task automatic set_unit(input int k, input logic [DW-1:0] v, input logic [DW-1:0] m);
        trig_value[k*DW +: DW] = v;
        trig_mask[k*DW +: DW]  = m;
    endtask

    // One clock: drive inputs, advance the model, then queue expected status.
    task automatic step(input logic [DW-1:0] d, input bit sen, input bit a,
                        input bit ab, input bit f);
        data_i = d; sample_en = sen; arm = a; abort = ab; force_trig = f;
        model_step(d, sen, a, ab, f);
        @(posedge clk); #1;
        arm = 0; abort = 0; force_trig = 0; sample_en = 0;
        push_status();
    endtask

    task automatic rd_at(input int k, input string n, input logic [63:0] e,
                         input logic [63:0] m);
        rd_addr = DL'(k);
        @(posedge clk); #1;
        push(n, 5, e, m);
    endtask

    task automatic readout_all();
        int base, cnt;
        cnt = m_count(); base = m_samp.size() - cnt;
        for (int k = 0; k < cnt; k++) rd_at(k, "rd_data", 64'(m_samp[base+k]), '1);
    endtask

    task automatic do_reset();
        reset = 1;
        model_reset();
        @(posedge clk); #1;
        check_now("rst_now_busy", 64'(busy), 64'h0);
        check_now("rst_now_triggered", 64'(triggered), 64'h0);
        check_now("rst_now_done", 64'(done), 64'h0);
        check_now("rst_now_sample_count", 64'(sample_count), 64'h0);
        check_now("rst_now_trig_offset", 64'(trig_offset), 64'h0);
        check_now("rst_now_rd_data", 64'(rd_data), 64'h0);
        reset = 0;
        push("rst_busy", 0, 64'h0, 64'h1);
        push("rst_triggered", 1, 64'h0, 64'h1);
        push("rst_done", 2, 64'h0, 64'h1);
        push("rst_sample_count", 3, 64'h0, '1);
        push("rst_trig_offset", 4, 64'h0, '1);
        push("rst_rd_data", 5, 64'h0, '1);
    endtask

    task automatic clear_cfg();
        trig_en = '0; trig_edge = '0; trig_and = 0; trig_value = '0; trig_mask = '0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset = 1; sample_en = 0; arm = 0; abort = 0; force_trig = 0;
        data_i = '0; rd_addr = '0; post_count = '0;
        clear_cfg();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Addr match at 0x0038, post 3, from 0x0030
        set_unit(0, DW'(16'h0038), DW'(16'hFFFF)); trig_en = 4'b0001; post_count = 4'd3;
        step(mk(0, 1, 1), 1, 1, 0, 0);
        for (int a = 16'h30; a <= 16'h3B; a++) step(mk(16'(a), 1, 1), 1, 0, 0, 0);
        push("t1_done", 2, 64'h1, 64'h1);
        push("t1_count", 3, 64'd12, '1);
        push("t1_offset", 4, 64'd8, '1);
        rd_at(8, "t1_rd8", 64'h0038, 64'hFFFF);
        rd_at(11, "t1_rd11", 64'h003B, 64'hFFFF);
        readout_all();

        // Same, from 0x0000 so the buffer wraps
        step(mk(0, 1, 1), 1, 1, 0, 0);
        for (int a = 0; a <= 16'h3B; a++) step(mk(16'(a), 1, 1), 1, 0, 0, 0);
        push("t2_count", 3, 64'd16, '1);
        push("t2_offset", 4, 64'd12, '1);
        rd_at(0, "t2_rd0", 64'h002C, 64'hFFFF);
        rd_at(15, "t2_rd15", 64'h003B, 64'hFFFF);
        readout_all();

        // Edge mode on iorq_n == 0
        clear_cfg();
        set_unit(0, '0, DW'(1) << 16); trig_en = 4'b0001; trig_edge = 4'b0001; post_count = 0;
        step(mk(0, 0, 1), 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(mk(16'(i), 0, 1), 1, 0, 0, 0);
        push("t3_no_edge", 1, 64'h0, 64'h1);
        step(mk(5, 1, 1), 1, 0, 0, 0);
        step(mk(6, 0, 1), 1, 0, 0, 0);
        push("t3_edge_trig", 1, 64'h1, 64'h1);
        push("t3_offset", 4, 64'd6, '1);
        readout_all();

        // AND of addr==0xA8 and rd_n==0, including a masked-off sample
        clear_cfg();
        set_unit(0, DW'(16'h00A8), DW'(16'hFFFF));
        set_unit(1, '0, DW'(1) << 17);
        trig_en = 4'b0011; trig_and = 1; post_count = 0;
        step(mk(0, 1, 1), 1, 1, 0, 0);
        step(mk(16'h00A8, 1, 1), 1, 0, 0, 0);
        push("t4_and_partial", 1, 64'h0, 64'h1);
        step(mk(16'h00A8, 1, 0), 0, 0, 0, 0);
        push("t4_sen0_notrig", 1, 64'h0, 64'h1);
        push("t4_sen0_count", 3, 64'd1, '1);
        step(mk(16'h0000, 1, 0), 1, 0, 0, 0);
        step(mk(16'h00A8, 1, 0), 1, 0, 0, 0);
        push("t4_and_trig", 2, 64'h1, 64'h1);
        push("t4_offset", 4, 64'd2, '1);
        readout_all();

        // Forced trigger, no units enabled
        clear_cfg(); post_count = 0;
        step(mk(0, 1, 1), 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(mk(16'(i), 1, 1), 1, 0, 0, 0);
        step(mk(16'h77, 1, 1), 0, 0, 0, 1);
        push("t5_pending_not_done", 2, 64'h0, 64'h1);
        step(mk(16'h55, 1, 1), 1, 0, 0, 0);
        push("t5_done", 2, 64'h1, 64'h1);
        push("t5_offset", 4, 64'd3, '1);
        push("t5_count", 3, 64'd4, '1);
        readout_all();

        // Arm ignored during WAIT_TRIG; abort during POST
        clear_cfg();
        set_unit(0, DW'(16'h0005), DW'(16'hFFFF)); trig_en = 4'b0001; post_count = 5;
        step(mk(0, 1, 1), 1, 1, 0, 0);
        step(mk(0, 1, 1), 1, 0, 0, 0);
        step(mk(1, 1, 1), 1, 0, 0, 0);
        step(mk(2, 1, 1), 1, 1, 0, 0);
        push("t6_arm_ignored", 3, 64'd3, '1);
        for (int a = 3; a <= 7; a++) step(mk(16'(a), 1, 1), 1, 0, 0, 0);
        push("t6_in_post", 0, 64'h1, 64'h1);
        step(mk(8, 1, 1), 0, 0, 1, 0);
        push("t6_abort_busy", 0, 64'h0, 64'h1);
        push("t6_abort_done", 2, 64'h0, 64'h1);
        readout_all();

        // Randomized captures
        for (int r = 0; r < 30; r++) begin
            clear_cfg();
            trig_en = NT'($urandom); trig_edge = NT'($urandom); trig_and = 1'($urandom);
            post_count = DL'($urandom);
            for (int k = 0; k < NT; k++)
                set_unit(k, DW'($urandom_range(0, 15)), DW'($urandom_range(0, 15)));
            step(mk(0, 1, 1), 1, 1, 0, 0);
            for (int c = 0; c < 80 && (m_ph == 1 || m_ph == 2); c++) begin
                bit ab, sen, f, a;
                ab  = ($urandom_range(0, 99) == 0);
                sen = ab ? 1'b0 : ($urandom_range(0, 3) != 0);
                f   = ($urandom_range(0, 29) == 0);
                a   = ($urandom_range(0, 19) == 0);
                step(mk(16'($urandom_range(0, 15)), 1'($urandom), 1'($urandom)), sen, a, ab, f);
            end
            if (m_ph == 1 || m_ph == 2) step(mk(0, 1, 1), 0, 0, 1, 0);
            readout_all();
        end

        // Reset in the middle of a capture
        clear_cfg(); post_count = 4;
        step(mk(0, 1, 1), 1, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(mk(16'(i), 1, 1), 1, 0, 0, 1);
        do_reset();

        @(negedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
